reg_bus_sequencer: RTL and testbench

Command-driven initiator for the 8×16-bit CPU register file. It accepts register-transfer commands over a valid/ready handshake and drives the register file's write port (select, data, enable) and read port (select, output enable). It samples the returned read data and performs the transfer as a multi-cycle sequence. It sits between the instruction decode/control unit and the register file, and owns all register-file port timing.

---
 rtl/reg_bus_sequencer_pkg.sv | 24 ++
 rtl/reg_bus_sequencer_if.sv | 47 ++++
 rtl/reg_bus_sequencer.sv | 134 +++++++++++++
 tb/tb_reg_bus_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_sequencer_pkg.sv
// reg_bus_sequencer shared types: op codes, FSM states, widths.
// Imported by the sequencer, decode and the bench.
package reg_seq_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    OP_LOADI = 2'b00,
    OP_MOV   = 2'b01,
    OP_SWAP  = 2'b10,
    OP_READ  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_B = 3'd4,
    ST_RESP = 3'd5
  } state_e;

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// Command, response and register-file port bundle of the sequencer.
// master = sequencer side, slave = control unit / register file side.
interface reg_bus_sequencer_if #(
  parameter int DATA_W = reg_seq_pkg::DATA_W,
  parameter int SEL_W  = reg_seq_pkg::SEL_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [SEL_W-1:0]  cmd_dst;
  logic [SEL_W-1:0]  cmd_src;
  logic [DATA_W-1:0] cmd_imm;
  logic [SEL_W-1:0]  rf_sel_in;
  logic [DATA_W-1:0] rf_data_in;
  logic              rf_write_enable;
  logic [SEL_W-1:0]  rf_sel_out;
  logic              rf_output_enable;
  logic [DATA_W-1:0] rf_data_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_dst,
    input  cmd_src, cmd_imm,
    input  rf_data_out, rsp_ready,
    output cmd_ready,
    output rf_sel_in, rf_data_in,
    output rf_write_enable,
    output rf_sel_out, rf_output_enable,
    output rsp_valid, rsp_data, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_dst,
    output cmd_src, cmd_imm,
    output rf_data_out, rsp_ready,
    input  cmd_ready,
    input  rf_sel_in, rf_data_in,
    input  rf_write_enable,
    input  rf_sel_out, rf_output_enable,
    input  rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/reg_bus_sequencer.sv
// Register-transfer sequencer: runs LOADI/MOV/SWAP/READ
// as multi-cycle read/write sequences on the register file ports.
module reg_bus_sequencer #(
  parameter int DATA_W = reg_seq_pkg::DATA_W,
  parameter int SEL_W  = reg_seq_pkg::SEL_W
) (
  input  logic                clk,
  input  logic                rst,
  reg_bus_sequencer_if.master bus
);

  import reg_seq_pkg::*;

  state_e            state;
  state_e            state_nx;
  op_e               op_q;
  logic [SEL_W-1:0]  dst_q;
  logic [SEL_W-1:0]  src_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] tmp0;
  logic [DATA_W-1:0] tmp1;
  logic              accept;

  assign accept = (state == ST_IDLE) && bus.cmd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (op_e'(bus.cmd_op) == OP_LOADI)
            state_nx = ST_WR_A;
          else
            state_nx = ST_RD_A;
        end
      end
      ST_RD_A: begin
        unique case (op_q)
          OP_MOV:  state_nx = ST_WR_A;
          OP_SWAP: state_nx = ST_RD_B;
          OP_READ: state_nx = ST_RESP;
          default: state_nx = ST_IDLE;
        endcase
      end
      ST_RD_B: state_nx = ST_WR_A;
      ST_WR_A: begin
        if (op_q == OP_SWAP)
          state_nx = ST_WR_B;
        else
          state_nx = ST_IDLE;
      end
      ST_WR_B: state_nx = ST_IDLE;
      ST_RESP: begin
        if (bus.rsp_ready)
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Latched command and read-back temporaries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_LOADI;
      dst_q <= '0;
      src_q <= '0;
      imm_q <= '0;
      tmp0  <= '0;
      tmp1  <= '0;
    end else begin
      if (accept) begin
        op_q  <= op_e'(bus.cmd_op);
        dst_q <= bus.cmd_dst;
        src_q <= bus.cmd_src;
        imm_q <= bus.cmd_imm;
      end
      if (state == ST_RD_A)
        tmp0 <= bus.rf_data_out;
      if (state == ST_RD_B)
        tmp1 <= bus.rf_data_out;
    end
  end

  // Port controls come from state and latched fields only
  always_comb begin
    bus.cmd_ready        = 1'b0;
    bus.rf_sel_in        = '0;
    bus.rf_data_in       = '0;
    bus.rf_write_enable  = 1'b0;
    bus.rf_sel_out       = '0;
    bus.rf_output_enable = 1'b0;
    bus.rsp_valid        = 1'b0;
    bus.rsp_data         = '0;
    bus.busy             = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: bus.cmd_ready = !rst;
      ST_RD_A: begin
        bus.rf_sel_out       = src_q;
        bus.rf_output_enable = 1'b1;
      end
      ST_RD_B: begin
        bus.rf_sel_out       = dst_q;
        bus.rf_output_enable = 1'b1;
      end
      ST_WR_A: begin
        bus.rf_sel_in       = dst_q;
        bus.rf_write_enable = 1'b1;
        if (op_q == OP_LOADI)
          bus.rf_data_in = imm_q;
        else
          bus.rf_data_in = tmp0;
      end
      ST_WR_B: begin
        bus.rf_sel_in       = src_q;
        bus.rf_data_in      = tmp1;
        bus.rf_write_enable = 1'b1;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = tmp0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: register file responder,
// command-level reference model and per-cycle port compare.
module tb_reg_bus_sequencer;

  import reg_seq_pkg::*;

  typedef struct packed {
    logic        we;
    logic [2:0]  si;
    logic [15:0] di;
    logic        oe;
    logic [2:0]  so;
    logic        rv;
    logic [15:0] rd;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [15:0] rf [8];
  logic [15:0] ref_rf [8];
  exp_t        q [$];

  reg_bus_sequencer_if #(.DATA_W(16), .SEL_W(3)) bus ();

  reg_bus_sequencer #(.DATA_W(16), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf[i]     = '0;
      ref_rf[i] = '0;
    end
  end

  // Register file responder
  always @(posedge clk)
    if (bus.rf_write_enable)
      rf[bus.rf_sel_in] <= bus.rf_data_in;

  assign bus.rf_data_out =
    bus.rf_output_enable ? rf[bus.rf_sel_out] : '0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_r(input logic [2:0] s);
    exp_t e;
    e    = '0;
    e.oe = 1'b1;
    e.so = s;
    return e;
  endfunction

  function automatic exp_t mk_w(input logic [2:0] s,
                                input logic [15:0] d);
    exp_t e;
    e    = '0;
    e.we = 1'b1;
    e.si = s;
    e.di = d;
    return e;
  endfunction

  function automatic exp_t mk_p(input logic [15:0] d);
    exp_t e;
    e    = '0;
    e.rv = 1'b1;
    e.rd = d;
    return e;
  endfunction

  // Command semantics expanded into the expected port cycles
  task automatic model_cmd(input op_e op,
                           input logic [2:0] d,
                           input logic [2:0] s,
                           input logic [15:0] imm);
    case (op)
      OP_LOADI: q.push_back(mk_w(d, imm));
      OP_MOV: begin
        q.push_back(mk_r(s));
        q.push_back(mk_w(d, ref_rf[s]));
      end
      OP_SWAP: begin
        q.push_back(mk_r(s));
        q.push_back(mk_r(d));
        q.push_back(mk_w(d, ref_rf[s]));
        q.push_back(mk_w(s, ref_rf[d]));
      end
      default: begin
        q.push_back(mk_r(s));
        q.push_back(mk_p(ref_rf[s]));
      end
    endcase
  endtask

  always @(negedge clk) begin
    logic [42:0] act;
    logic [42:0] ex;
    exp_t        e;
    bit          idle;
    act = {bus.cmd_ready, bus.busy,
           bus.rf_write_enable, bus.rf_sel_in,
           bus.rf_data_in, bus.rf_output_enable,
           bus.rf_sel_out, bus.rsp_valid, bus.rsp_data};
    check("we_oe_excl",
          {63'd0, bus.rf_write_enable && bus.rf_output_enable},
          64'd0);
    if (rst) begin
      check("reset_outs", {21'd0, act}, 64'd0);
      q.delete();
    end else begin
      idle = (q.size() == 0);
      e    = '0;
      if (idle)
        ex = {2'b10, 41'd0};
      else begin
        e  = q[0];
        ex = {2'b01, e};
      end
      check("cycle", {21'd0, act}, {21'd0, ex});
      if (!idle) begin
        if (!e.rv || bus.rsp_ready) begin
          if (e.we)
            ref_rf[e.si] = e.di;
          void'(q.pop_front());
        end
      end else if (bus.cmd_valid) begin
        model_cmd(op_e'(bus.cmd_op), bus.cmd_dst,
                  bus.cmd_src, bus.cmd_imm);
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    if (k == 50)
      check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic send(input op_e op,
                      input logic [2:0] d,
                      input logic [2:0] s,
                      input logic [15:0] imm,
                      output int n);
    int k;
    wait_idle();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_dst   = d;
    bus.cmd_src   = s;
    bus.cmd_imm   = imm;
    n = 1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      n++;
    end
    if (k == 100)
      check("busy_timeout", 64'd1, 64'd0);
  endtask

  task automatic rsp_stall();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    if (k == 50)
      check("rsp_timeout", 64'd1, 64'd0);
    check("rsp_hold1", {bus.rsp_valid, bus.rsp_data},
          64'h1_0F0F);
    repeat (2) begin
      @(negedge clk);
      check("rsp_hold", {bus.rsp_valid, bus.rsp_data},
            64'h1_0F0F);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_hold4", {bus.rsp_valid, bus.rsp_data},
          64'h1_0F0F);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_dst   = '0;
    bus.cmd_src   = '0;
    bus.cmd_imm   = '0;
    bus.rsp_ready = 1'b1;
    #2;
    check("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {63'd0, bus.cmd_ready}, 64'd1);

    send(OP_LOADI, 3'd3, 3'd0, 16'hBEEF, n);
    check("loadi_cycles", n, 2);
    check("r3", rf[3], 16'hBEEF);

    send(OP_LOADI, 3'd1, 3'd0, 16'h1234, n);
    send(OP_MOV, 3'd5, 3'd1, 16'h0, n);
    check("mov_cycles", n, 3);
    check("r5", rf[5], 16'h1234);
    check("r1", rf[1], 16'h1234);

    send(OP_LOADI, 3'd2, 3'd0, 16'hAAAA, n);
    send(OP_LOADI, 3'd6, 3'd0, 16'h5555, n);
    send(OP_LOADI, 3'd4, 3'd0, 16'h4444, n);
    send(OP_SWAP, 3'd6, 3'd2, 16'h0, n);
    check("swap_cycles", n, 5);
    check("r2", rf[2], 16'h5555);
    check("r6", rf[6], 16'hAAAA);
    send(OP_SWAP, 3'd4, 3'd4, 16'h0, n);
    check("swap_same_cycles", n, 5);
    check("r4", rf[4], 16'h4444);

    send(OP_LOADI, 3'd7, 3'd0, 16'h0F0F, n);
    bus.rsp_ready = 1'b0;
    fork
      send(OP_READ, 3'd0, 3'd7, 16'h0, n);
      rsp_stall();
    join
    check("read_stall_cycles", n, 6);
    bus.rsp_ready = 1'b1;
    send(OP_LOADI, 3'd0, 3'd0, 16'h7777, n);
    check("after_read_cycles", n, 2);
    send(OP_READ, 3'd0, 3'd2, 16'h0, n);
    check("read_cycles", n, 3);

    // cmd_valid held through a SWAP with fields changing
    wait_idle();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_SWAP;
    bus.cmd_dst   = 3'd5;
    bus.cmd_src   = 3'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.cmd_op  = op_e'(i[1:0]);
      bus.cmd_dst = 3'(i);
      bus.cmd_src = 3'(7 - i);
      bus.cmd_imm = 16'hDEAD;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("held_r3", rf[3], 16'h1234);
    check("held_r5", rf[5], 16'hBEEF);

    // reset while a MOV sits in its write cycle
    wait_idle();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_MOV;
    bus.cmd_dst   = 3'd0;
    bus.cmd_src   = 3'd2;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("wr_a_we", {63'd0, bus.rf_write_enable}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_we_drop", {63'd0, bus.rf_write_enable}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_idle", {63'd0, bus.cmd_ready}, 64'd1);
    check("r0_kept", rf[0], 16'h7777);

    send(OP_LOADI, 3'd6, 3'd0, 16'h0001, n);
    check("post_rst_cycles", n, 2);
    for (int i = 0; i < 8; i++)
      check("regs_vs_model", rf[i], ref_rf[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
